// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Data-side access engine between the execute stage and the data
//             port (port B) of the dual-port memory. Accepts byte/half/word
//             loads and stores over a valid/ready request, issues word-aligned
//             memory ops, extracts and sign/zero-extends load data and does a
//             read-modify-write for sub-word stores. One response pulse per
//             accepted request; bad requests complete with resp_err.
//  Ports    : clk, reset (async, active-low)
//             req_valid/req_ready, req_store, req_size, req_unsigned,
//             req_addr, req_wdata                 - request channel
//             resp_valid, resp_err, resp_rdata    - completion channel
//             mem_op, mem_addr, mem_wdata         - registered memory command
//             mem_rdata, mem_rvalid               - memory read return
//  Config   : LSU_RMW_EN - when defined, sub-word stores run the RMW
//             sequence; otherwise they complete with an error and the RMW
//             states are not built.
//  Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [1:0]  mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    // Wait counter value at which the wait state gives up.
    localparam logic [3:0] c_TIMEOUT_LAST = 4'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD       = 3'd1,
        S_RD_WAIT  = 3'd2,
`ifdef LSU_RMW_EN
        S_RMW_RD   = 3'd3,
        S_RMW_WAIT = 3'd4,
        S_RMW_WR   = 3'd5,
`endif
        S_WR       = 3'd6
    } state_t;

    state_t      r_state, w_nextState;

    logic [1:0]  r_size;
    logic        r_unsigned;
    logic [1:0]  r_addrLo;
    logic [3:0]  r_waitCnt,   w_waitCntNext;
    logic [1:0]  r_memOp,     w_memOpNext;
    logic [31:0] r_memAddr,   w_memAddrNext;
    logic [31:0] r_memWdata,  w_memWdataNext;
    logic        r_respValid, w_respValid;
    logic        r_respErr,   w_respErr;
    logic [31:0] r_respRdata, w_respRdata;

    logic        w_accept;
    logic        w_misaligned;
    logic        w_waitExpired;

`ifdef LSU_RMW_EN
    logic [15:0] r_wdata;

    // Replace only the addressed lane(s) of the read word with store data.
    function automatic logic [31:0] mergeStore(input logic [31:0] word,
                                               input logic [15:0] wd,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lo);
        logic [31:0] m;
        m = word;
        if (size == 2'b00) begin
            case (lo)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (lo[1]) begin
            m[31:16] = wd;
        end else begin
            m[15:0]  = wd;
        end
        return m;
    endfunction
`endif

    function automatic logic [31:0] extractLoad(input logic [31:0] data,
                                                input logic [1:0]  size,
                                                input logic [1:0]  lo,
                                                input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        case (size)
            2'b00:   r = {{24{b[7] & ~uns}}, b};
            2'b01:   r = {{16{h[15] & ~uns}}, h};
            default: r = data;
        endcase
        return r;
    endfunction

    assign req_ready    = (r_state == S_IDLE) && reset;
    assign w_accept     = req_valid && req_ready;
    assign w_misaligned = (req_size == 2'b11)
                       || ((req_size == 2'b01) && req_addr[0])
                       || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
    assign w_waitExpired = (r_waitCnt == c_TIMEOUT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState    = r_state;
        w_waitCntNext  = r_waitCnt;
        w_memAddrNext  = r_memAddr;
        w_memWdataNext = r_memWdata;
        w_respValid    = 1'b0;
        w_respErr      = 1'b0;
        w_respRdata    = 32'd0;
        w_memOpNext    = MEM_DISABLE;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_memAddrNext = {req_addr[31:2], 2'b00};
                    if (w_misaligned) begin
                        w_respValid = 1'b1;
                        w_respErr   = 1'b1;
                    end else if (!req_store) begin
                        w_nextState = S_RD;
                    end else if (req_size == 2'b10) begin
                        w_nextState    = S_WR;
                        w_memWdataNext = req_wdata;
                    end else begin
`ifdef LSU_RMW_EN
                        w_nextState = S_RMW_RD;
`else
                        w_respValid = 1'b1;
                        w_respErr   = 1'b1;
`endif
                    end
                end
            end
            S_RD: begin
                w_nextState   = S_RD_WAIT;
                w_waitCntNext = 4'd0;
            end
            S_RD_WAIT: begin
                if (mem_rvalid) begin
                    w_nextState = S_IDLE;
                    w_respValid = 1'b1;
                    w_respRdata = extractLoad(mem_rdata, r_size, r_addrLo, r_unsigned);
                end else if (w_waitExpired) begin
                    w_nextState = S_IDLE;
                    w_respValid = 1'b1;
                    w_respErr   = 1'b1;
                end else begin
                    w_waitCntNext = r_waitCnt + 4'd1;
                end
            end
`ifdef LSU_RMW_EN
            S_RMW_RD: begin
                w_nextState   = S_RMW_WAIT;
                w_waitCntNext = 4'd0;
            end
            S_RMW_WAIT: begin
                if (mem_rvalid) begin
                    w_nextState    = S_RMW_WR;
                    w_memWdataNext = mergeStore(mem_rdata, r_wdata, r_size, r_addrLo);
                end else if (w_waitExpired) begin
                    // Abandon the store: the write is never issued.
                    w_nextState = S_IDLE;
                    w_respValid = 1'b1;
                    w_respErr   = 1'b1;
                end else begin
                    w_waitCntNext = r_waitCnt + 4'd1;
                end
            end
            S_RMW_WR: begin
                w_nextState = S_IDLE;
                w_respValid = 1'b1;
            end
`endif
            S_WR: begin
                w_nextState = S_IDLE;
                w_respValid = 1'b1;
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase

        // mem_op is registered, so it is derived from the state being entered.
        // S_RD is only entered from IDLE on accept, so req_unsigned is live.
        case (w_nextState)
            S_RD:     w_memOpNext = req_unsigned ? MEM_READ_ZEXT : MEM_READ_SEXT;
`ifdef LSU_RMW_EN
            S_RMW_RD: w_memOpNext = MEM_READ_ZEXT;
            S_RMW_WR: w_memOpNext = MEM_WRITE;
`endif
            S_WR:     w_memOpNext = MEM_WRITE;
            default:  w_memOpNext = MEM_DISABLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_size      <= 2'b00;
            r_unsigned  <= 1'b0;
            r_addrLo    <= 2'b00;
            r_waitCnt   <= 4'd0;
            r_memOp     <= MEM_DISABLE;
            r_memAddr   <= 32'd0;
            r_memWdata  <= 32'd0;
            r_respValid <= 1'b0;
            r_respErr   <= 1'b0;
            r_respRdata <= 32'd0;
        end else begin
            if (w_accept) begin
                r_size     <= req_size;
                r_unsigned <= req_unsigned;
                r_addrLo   <= req_addr[1:0];
            end
            r_waitCnt   <= w_waitCntNext;
            r_memOp     <= w_memOpNext;
            r_memAddr   <= w_memAddrNext;
            r_memWdata  <= w_memWdataNext;
            r_respValid <= w_respValid;
            r_respErr   <= w_respErr;
            r_respRdata <= w_respRdata;
        end
    end

`ifdef LSU_RMW_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wdata <= 16'd0;
        end else if (w_accept) begin
            r_wdata <= req_wdata[15:0];
        end
    end
`endif

    assign mem_op     = r_memOp;
    assign mem_addr   = r_memAddr;
    assign mem_wdata  = r_memWdata;
    assign resp_valid = r_respValid;
    assign resp_err   = r_respErr;
    assign resp_rdata = r_respRdata;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed self-checking bench for load_store_unit with a small
//             port-B memory model (one-cycle read latency, optional stall).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [1:0]  mem_op;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'd0;
    logic        mem_rvalid = 1'b0;

    logic [31:0] mem [0:63];
    logic        memStall = 1'b0;
    logic        memLoad = 1'b0;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_store    (req_store),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_err     (resp_err),
        .resp_rdata   (resp_rdata),
        .mem_op       (mem_op),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_rvalid   (mem_rvalid)
    );

    // Port-B memory model: read data returns the cycle after the op is sampled.
    always @(posedge clk) begin
        mem_rvalid <= 1'b0;
        if (memLoad) begin
            mem[16] <= 32'h808182F3;
            mem[17] <= 32'h00000000;
        end else begin
            if ((mem_op == 2'b01 || mem_op == 2'b10) && !memStall) begin
                mem_rvalid <= 1'b1;
                mem_rdata  <= mem[mem_addr[7:2]];
            end
            if (mem_op == 2'b11) begin
                mem[mem_addr[7:2]] <= mem_wdata;
            end
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Issue one request (called at a negedge with the unit idle) and wait for
    // its response. lat = clock edges after the accept edge before resp_valid
    // is seen (-1 if none); trace packs mem_op per cycle; anyOp flags any op.
    task automatic doReq(input logic st, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rdata, output logic err,
                         output int lat, output logic [31:0] trace,
                         output logic anyOp, output logic [31:0] wrData,
                         output logic pulseLow);
        req_valid = 1'b1; req_store = st; req_size = sz;
        req_unsigned = uns; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        // Scramble the request fields: the unit must have latched them.
        req_valid = 1'b0; req_store = ~st; req_size = 2'b11;
        req_unsigned = ~uns; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
        lat = -1; rdata = 32'hX; err = 1'bX; trace = 32'd0; anyOp = 1'b0;
        wrData = 32'd0; pulseLow = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            trace = {trace[29:0], mem_op};
            if (mem_op != 2'b00) anyOp = 1'b1;
            if (mem_op == 2'b11) wrData = mem_wdata;
            if (resp_valid) begin
                lat = i; rdata = resp_rdata; err = resp_err;
                break;
            end
        end
        @(negedge clk);
        pulseLow = ~resp_valid;
    endtask

    logic [31:0] rd, tr, wrd;
    logic        er, ao, pl;
    int          lt;

    initial begin
        #200000;
        $display("FAIL watchdog: got 0x%08h expected 0x%08h", 32'd1, 32'd0);
        $fatal(1, "watchdog expired");
    end

    initial begin
        // ---------------- reset ----------------
        memLoad = 1'b1;
        repeat (2) @(negedge clk);
        memLoad = 1'b0;
        checkValue("rst_ready",  {31'd0, req_ready},  32'd0);
        checkValue("rst_rvalid", {31'd0, resp_valid}, 32'd0);
        checkValue("rst_memop",  {30'd0, mem_op},     32'd0);
        checkValue("rst_memaddr", mem_addr,           32'd0);
        checkValue("rst_wdata",  mem_wdata,           32'd0);
        checkValue("rst_rdata",  resp_rdata,          32'd0);
        reset = 1'b1;
        @(negedge clk);
        checkValue("ready_after_rst", {31'd0, req_ready}, 32'd1);

        // ---------------- loads ----------------
        doReq(1'b0, 2'b00, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lb40_data", rd, 32'hFFFFFFF3);
        checkValue("lb40_err",  {31'd0, er}, 32'd0);
        checkValue("lb40_lat",  32'(lt), 32'd2);
        checkValue("lb40_memaddr", mem_addr, 32'h40);

        doReq(1'b0, 2'b00, 1'b1, 32'h43, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lbu43_data", rd, 32'h00000080);

        doReq(1'b0, 2'b00, 1'b0, 32'h41, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lb41_data", rd, 32'hFFFFFF82);

        doReq(1'b0, 2'b01, 1'b0, 32'h42, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lh42_data", rd, 32'hFFFF8081);

        doReq(1'b0, 2'b01, 1'b1, 32'h42, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lhu42_data", rd, 32'h00008081);
        checkValue("lhu42_trace", tr, 32'h20);

        doReq(1'b0, 2'b01, 1'b1, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lhu40_data", rd, 32'h000082F3);

        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw40_data",  rd, 32'h808182F3);
        checkValue("lw40_trace", tr, 32'h10);
        checkValue("lw40_pulse", {31'd0, pl}, 32'd1);

        // ---------------- misaligned / illegal ----------------
        doReq(1'b1, 2'b10, 1'b0, 32'h43, 32'h12345678, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sw43_err",   {31'd0, er}, 32'd1);
        checkValue("sw43_lat",   32'(lt), 32'd0);
        checkValue("sw43_noop",  {31'd0, ao}, 32'd0);
        checkValue("sw43_rdata", rd, 32'd0);

        doReq(1'b0, 2'b01, 1'b0, 32'h41, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lh41_err",  {31'd0, er}, 32'd1);
        checkValue("lh41_noop", {31'd0, ao}, 32'd0);

        doReq(1'b0, 2'b11, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("size11_err", {31'd0, er}, 32'd1);

        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw40_unchanged", rd, 32'h808182F3);

        // ---------------- reset mid-operation ----------------
`ifdef LSU_RMW_EN
        req_valid = 1'b1; req_store = 1'b1; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h41; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);                       // now in RMW_WAIT
`else
        req_valid = 1'b1; req_store = 1'b0; req_size = 2'b10;
        req_unsigned = 1'b0; req_addr = 32'h40; req_wdata = 32'h0;
        @(posedge clk);
        @(negedge clk);                       // now in RD, op on the bus
        req_valid = 1'b0;
`endif
        reset = 1'b0;
        #1;
        checkValue("midrst_memop", {30'd0, mem_op}, 32'd0);
        checkValue("midrst_ready", {31'd0, req_ready}, 32'd0);
        ao = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (resp_valid) ao = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        if (resp_valid) ao = 1'b1;
        checkValue("midrst_noresp", {31'd0, ao}, 32'd0);
        checkValue("midrst_ready_rel", {31'd0, req_ready}, 32'd1);
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("midrst_word", rd, 32'h808182F3);

        // ---------------- sub-word stores ----------------
`ifdef LSU_RMW_EN
        doReq(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sb41_err",   {31'd0, er}, 32'd0);
        checkValue("sb41_lat",   32'(lt), 32'd3);
        checkValue("sb41_trace", tr, 32'h8C);
        checkValue("sb41_wdata", wrd, 32'h8081AAF3);
        checkValue("sb41_rdata", rd, 32'd0);
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw_after_sb", rd, 32'h8081AAF3);
        doReq(1'b1, 2'b01, 1'b0, 32'h42, 32'hFFFF1234, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sh42_err", {31'd0, er}, 32'd0);
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw_after_sh", rd, 32'h1234AAF3);
`else
        doReq(1'b1, 2'b00, 1'b0, 32'h41, 32'h000000AA, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sb41_err",  {31'd0, er}, 32'd1);
        checkValue("sb41_lat",  32'(lt), 32'd0);
        checkValue("sb41_noop", {31'd0, ao}, 32'd0);
        doReq(1'b1, 2'b01, 1'b0, 32'h40, 32'h00001234, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sh40_err",  {31'd0, er}, 32'd1);
        checkValue("sh40_noop", {31'd0, ao}, 32'd0);
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw_after_sh", rd, 32'h808182F3);
`endif

        // ---------------- word store ----------------
        doReq(1'b1, 2'b10, 1'b0, 32'h44, 32'hCAFEF00D, rd, er, lt, tr, ao, wrd, pl);
        checkValue("sw44_err",   {31'd0, er}, 32'd0);
        checkValue("sw44_lat",   32'(lt), 32'd1);
        checkValue("sw44_trace", tr, 32'hC);
        checkValue("sw44_mem",   mem[17], 32'hCAFEF00D);
        doReq(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("lw44_data", rd, 32'hCAFEF00D);

        // ---------------- read timeout ----------------
        memStall = 1'b1;
        doReq(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("tmo_err",   {31'd0, er}, 32'd1);
        checkValue("tmo_lat",   32'(lt), 32'd16);
        checkValue("tmo_rdata", rd, 32'd0);
        memStall = 1'b0;
        doReq(1'b0, 2'b00, 1'b1, 32'h40, 32'h0, rd, er, lt, tr, ao, wrd, pl);
        checkValue("post_tmo_lbu", rd, {24'd0, mem[16][7:0]} == 32'd0 ? 32'hFFFFFFFF : 32'h000000F3);

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
